int_reg_readout: RTL and testbench

- Computer-side counterpart to the LVDA interrupt/countdown processing logic.
- Latches discrete interrupt sources into a pending register and drives the summary SINT level.
- Serves PIO commands from the LVDC serial data path: read interrupt register (serial out), reset selected interrupts (serial mask in), load inhibit mask (serial in).
- Sits between the interrupt source conditioning and the LVDC PIO/serial channel.

---
 rtl/int_reg_readout_pkg.sv | 22 ++
 rtl/int_reg_readout_if.sv | 31 +++
 rtl/int_shift_reg.sv | 43 ++++
 rtl/int_reg_readout.sv | 116 +++++++++++
 tb/tb_int_reg_readout.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_reg_readout_pkg.sv
// Shared types and defaults for the interrupt register readout block.
// Holds the command FSM state set, default sizes and the bit-counter width rule.
package int_reg_pkg;

    localparam int DEF_NUM_INT   = 12;
    localparam int DEF_WORD_BITS = 26;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        SHIFT_IN_RST,
        SHIFT_IN_INH,
        APPLY_RST,
        APPLY_INH
    } state_t;

    // The counter must be able to hold WORD_BITS itself, so it never wraps.
    function automatic int cnt_width(input int word_bits);
        return $clog2(word_bits + 1);
    endfunction

endpackage

// File: rtl/int_reg_readout_if.sv
// Interrupt sources, PIO command pulses and serial channel of int_reg_readout.
// The master side is the LVDC/source conditioning; the slave side is the block.
interface int_reg_readout_if
    import int_reg_pkg::*;
#(
    parameter int NUM_INT = DEF_NUM_INT
) ();

    logic [NUM_INT-1:0] INTR_SRC;
    logic               BIT_STB;
    logic               RD_REQ;
    logic               RST_REQ;
    logic               INH_REQ;
    logic               SDI;
    logic               SDO;
    logic               SDO_VALID;
    logic               BUSY;
    logic               SINT;
    logic [NUM_INT-1:0] INT_PEND;

    modport master (
        output INTR_SRC, BIT_STB, RD_REQ, RST_REQ, INH_REQ, SDI,
        input  SDO, SDO_VALID, BUSY, SINT, INT_PEND
    );

    modport slave (
        input  INTR_SRC, BIT_STB, RD_REQ, RST_REQ, INH_REQ, SDI,
        output SDO, SDO_VALID, BUSY, SINT, INT_PEND
    );

endinterface

// File: rtl/int_shift_reg.sv
// Serial word shift register: parallel load of the low PAR_BITS, LSB-first shift
// with serial fill at the top, and a bit counter that flags the last bit of a word.
module int_shift_reg
    import int_reg_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS,
    parameter int PAR_BITS  = DEF_NUM_INT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PAR_BITS-1:0] load_val,
    input  logic                shift,
    input  logic                ser_in,
    output logic                ser_out,
    output logic [PAR_BITS-1:0] par_out,
    output logic                done
);

    localparam int CW = cnt_width(WORD_BITS);

    logic [WORD_BITS-1:0] shreg;
    logic [CW-1:0]        count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= WORD_BITS'(load_val);
            count <= '0;
        end else if (shift) begin
            shreg <= {ser_in, shreg[WORD_BITS-1:1]};
            count <= count + CW'(1);
        end
    end

    // Asserted on the strobe that brings the count up to a full word.
    assign done    = shift && (count == CW'(WORD_BITS - 1));
    assign ser_out = shreg[0];
    assign par_out = shreg[PAR_BITS-1:0];

endmodule

// File: rtl/int_reg_readout.sv
// Interrupt pending register with inhibit mask, SINT summary and a PIO command
// FSM that reads the register out serially or shifts in reset/inhibit masks.
module int_reg_readout
    import int_reg_pkg::*;
#(
    parameter int NUM_INT   = DEF_NUM_INT,
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic                SIM_CLK,
    input  logic                SIM_RST,
    int_reg_readout_if.slave    bus
);

    state_t             state, state_nx;
    logic [NUM_INT-1:0] pend, pend_nx;
    logic [NUM_INT-1:0] inh, inh_nx;
    logic [NUM_INT-1:0] src_prev;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] load_val;
    logic [NUM_INT-1:0] mask;
    logic               sint;
    logic               load;
    logic               shift;
    logic               ser_in;
    logic               ser_out;
    logic               done;

    int_shift_reg #(
        .WORD_BITS (WORD_BITS),
        .PAR_BITS  (NUM_INT)
    ) u_shift (
        .clk      (SIM_CLK),
        .rst      (SIM_RST),
        .load     (load),
        .load_val (load_val),
        .shift    (shift),
        .ser_in   (ser_in),
        .ser_out  (ser_out),
        .par_out  (mask),
        .done     (done)
    );

    // Inhibited bits never see an edge, so they cannot latch while masked.
    assign rise = bus.INTR_SRC & ~src_prev & ~inh;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        load_val = '0;
        shift    = 1'b0;
        ser_in   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.RD_REQ) begin
                    state_nx = SHIFT_OUT;
                    load     = 1'b1;
                    load_val = pend;
                end else if (bus.RST_REQ) begin
                    state_nx = SHIFT_IN_RST;
                    load     = 1'b1;
                end else if (bus.INH_REQ) begin
                    state_nx = SHIFT_IN_INH;
                    load     = 1'b1;
                end
            end
            SHIFT_OUT: begin
                shift = bus.BIT_STB;
                if (done) state_nx = IDLE;
            end
            SHIFT_IN_RST: begin
                shift  = bus.BIT_STB;
                ser_in = bus.SDI;
                if (done) state_nx = APPLY_RST;
            end
            SHIFT_IN_INH: begin
                shift  = bus.BIT_STB;
                ser_in = bus.SDI;
                if (done) state_nx = APPLY_INH;
            end
            APPLY_RST: state_nx = IDLE;
            APPLY_INH: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // A fresh edge in the clear cycle wins, so no interrupt is lost.
    always_comb begin
        pend_nx = pend | rise;
        inh_nx  = inh;
        if (state == APPLY_RST) pend_nx = (pend & ~mask) | rise;
        if (state == APPLY_INH) inh_nx  = mask;
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state    <= IDLE;
            pend     <= '0;
            inh      <= '0;
            src_prev <= '0;
            sint     <= 1'b0;
        end else begin
            state    <= state_nx;
            pend     <= pend_nx;
            inh      <= inh_nx;
            src_prev <= bus.INTR_SRC;
            sint     <= |(pend & ~inh);
        end
    end

    assign bus.SDO       = (state == SHIFT_OUT) & ser_out;
    assign bus.SDO_VALID = (state == SHIFT_OUT);
    assign bus.BUSY      = (state != IDLE);
    assign bus.SINT      = sint;
    assign bus.INT_PEND  = pend;

endmodule

// File: tb/tb_int_reg_readout.sv
// Bench for int_reg_readout: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_int_reg_readout;

    localparam int NI = 12;
    localparam int WB = 26;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b1;

    int_reg_readout_if #(.NUM_INT(NI)) ifc ();

    int_reg_readout #(.NUM_INT(NI), .WORD_BITS(WB)) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .bus     (ifc)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: kind 0 none, 1 read, 2 reset-mask, 3 inhibit-mask; apply holds the
    // kind of a fully received mask for its one commit cycle.
    logic [NI-1:0] m_pend, m_inh, m_prev;
    logic          m_sint;
    int            m_kind, m_k, m_apply;
    logic [WB-1:0] m_word, m_rx;

    always @(posedge SIM_CLK or posedge SIM_RST) begin : model
        logic [NI-1:0] r, n_pend, n_inh;
        logic [WB-1:0] n_word, n_rx;
        int            n_kind, n_k, n_apply;
        if (SIM_RST) begin
            m_pend  <= '0;
            m_inh   <= '0;
            m_prev  <= '0;
            m_sint  <= 1'b0;
            m_kind  <= 0;
            m_k     <= 0;
            m_apply <= 0;
            m_word  <= '0;
            m_rx    <= '0;
        end else begin
            r      = ifc.INTR_SRC & ~m_prev & ~m_inh;
            n_pend = (m_apply == 2) ? ((m_pend & ~m_rx[NI-1:0]) | r) : (m_pend | r);
            n_inh  = (m_apply == 3) ? m_rx[NI-1:0] : m_inh;
            n_kind = m_kind; n_k = m_k; n_word = m_word; n_rx = m_rx; n_apply = 0;
            if (m_apply != 0) begin
                n_kind = 0;
            end else if (m_kind == 0) begin
                if (ifc.RD_REQ) begin
                    n_kind = 1; n_k = 0; n_word = '0; n_word[NI-1:0] = m_pend;
                end else if (ifc.RST_REQ) begin
                    n_kind = 2; n_k = 0; n_rx = '0;
                end else if (ifc.INH_REQ) begin
                    n_kind = 3; n_k = 0; n_rx = '0;
                end
            end else if (ifc.BIT_STB) begin
                if (m_kind != 1) n_rx[m_k] = ifc.SDI;
                n_k = m_k + 1;
                if (n_k == WB) begin
                    n_apply = (m_kind == 1) ? 0 : m_kind;
                    n_kind  = 0;
                end
            end
            m_sint  <= |(m_pend & ~m_inh);
            m_pend  <= n_pend;
            m_inh   <= n_inh;
            m_prev  <= ifc.INTR_SRC;
            m_kind  <= n_kind;
            m_k     <= n_k;
            m_word  <= n_word;
            m_rx    <= n_rx;
            m_apply <= n_apply;
        end
    end

    always @(negedge SIM_CLK) begin
        if (!SIM_RST) begin
            check("pend", 32'(ifc.INT_PEND), 32'(m_pend));
            check("sint", 32'(ifc.SINT), 32'(m_sint));
            check("busy", 32'(ifc.BUSY), 32'(m_kind != 0 || m_apply != 0));
            check("sdo_valid", 32'(ifc.SDO_VALID), 32'(m_kind == 1));
            check("sdo", 32'(ifc.SDO), 32'((m_kind == 1) ? m_word[m_k] : 1'b0));
        end
    end

    task automatic cyc();
        @(negedge SIM_CLK);
        #1;
    endtask

    task automatic pulse_src(input logic [NI-1:0] v);
        ifc.INTR_SRC = v;
        cyc();
        ifc.INTR_SRC = '0;
        cyc();
    endtask

    task automatic send_word(input logic [WB-1:0] m);
        for (int b = 0; b < WB; b++) begin
            ifc.SDI     = m[b];
            ifc.BIT_STB = 1'b1;
            cyc();
        end
        ifc.BIT_STB = 1'b0;
        ifc.SDI     = 1'b0;
    endtask

    // which: 0 = reset interrupts, 1 = load inhibit; returns once back in IDLE.
    task automatic command(input int which, input logic [WB-1:0] m);
        if (which == 0) ifc.RST_REQ = 1'b1; else ifc.INH_REQ = 1'b1;
        cyc();
        ifc.RST_REQ = 1'b0;
        ifc.INH_REQ = 1'b0;
        send_word(m);
        cyc();
    endtask

    initial begin
        logic [WB-1:0] rd_word;
        ifc.INTR_SRC = '0;
        ifc.BIT_STB  = 1'b0;
        ifc.RD_REQ   = 1'b0;
        ifc.RST_REQ  = 1'b0;
        ifc.INH_REQ  = 1'b0;
        ifc.SDI      = 1'b0;
        repeat (3) cyc();
        SIM_RST = 1'b0;
        cyc();
        check("rst_pend", 32'(ifc.INT_PEND), 32'h0);
        check("rst_sint", 32'(ifc.SINT), 32'h0);
        check("rst_busy", 32'(ifc.BUSY), 32'h0);
        check("rst_valid", 32'(ifc.SDO_VALID), 32'h0);
        check("rst_sdo", 32'(ifc.SDO), 32'h0);

        // Edge latency and level-held source not re-latching after clear.
        ifc.INTR_SRC = 12'h008;
        cyc();
        check("lat_pend", 32'(ifc.INT_PEND), 32'h008);
        check("lat_sint0", 32'(ifc.SINT), 32'h0);
        cyc();
        check("lat_sint1", 32'(ifc.SINT), 32'h1);
        command(0, 26'h008);
        cyc(); cyc();
        check("held_pend", 32'(ifc.INT_PEND), 32'h0);
        check("held_sint", 32'(ifc.SINT), 32'h0);
        ifc.INTR_SRC = '0;
        cyc();

        // Serial read of 0x805 with a new edge arriving mid-word.
        pulse_src(12'h805);
        check("rd_pre", 32'(ifc.INT_PEND), 32'h805);
        ifc.RD_REQ = 1'b1;
        cyc();
        ifc.RD_REQ = 1'b0;
        rd_word = '0;
        for (int b = 0; b < WB; b++) begin
            check("rd_valid", 32'(ifc.SDO_VALID), 32'h1);
            rd_word[b] = ifc.SDO;
            if (b == 10) ifc.INTR_SRC = 12'h002;
            if (b == 11) ifc.INTR_SRC = 12'h000;
            ifc.BIT_STB = 1'b1;
            cyc();
            ifc.BIT_STB = 1'b0;
            cyc();
        end
        check("rd_word", 32'(rd_word), 32'h805);
        check("rd_valid_end", 32'(ifc.SDO_VALID), 32'h0);
        check("rd_busy_end", 32'(ifc.BUSY), 32'h0);
        check("rd_pend_after", 32'(ifc.INT_PEND), 32'h807);

        // Reset mask, then reset mask with a set in the apply cycle.
        command(0, '1);
        check("clr_all", 32'(ifc.INT_PEND), 32'h0);
        pulse_src(12'h00F);
        command(0, 26'h005);
        check("rst_mask", 32'(ifc.INT_PEND), 32'h00A);
        pulse_src(12'h005);
        ifc.RST_REQ = 1'b1;
        cyc();
        ifc.RST_REQ = 1'b0;
        send_word(26'h005);
        ifc.INTR_SRC = 12'h001;
        cyc();
        ifc.INTR_SRC = '0;
        check("rst_set_wins", 32'(ifc.INT_PEND), 32'h00B);

        // Inhibit: blocks new edges, masks already pending bits from SINT.
        command(0, '1);
        command(1, 26'h010);
        pulse_src(12'h010);
        check("inh_block_pend", 32'(ifc.INT_PEND), 32'h0);
        check("inh_block_sint", 32'(ifc.SINT), 32'h0);
        command(1, 26'h0);
        pulse_src(12'h010);
        check("inh_pre_pend", 32'(ifc.INT_PEND), 32'h010);
        check("inh_pre_sint", 32'(ifc.SINT), 32'h1);
        command(1, 26'h010);
        cyc();
        check("inh_keep_pend", 32'(ifc.INT_PEND), 32'h010);
        check("inh_mask_sint", 32'(ifc.SINT), 32'h0);
        pulse_src(12'h020);
        check("inh_other_pend", 32'(ifc.INT_PEND), 32'h030);
        check("inh_other_sint", 32'(ifc.SINT), 32'h1);
        command(1, 26'h0);
        command(0, '1);
        cyc(); cyc();
        check("inh_clean", 32'(ifc.INT_PEND), 32'h0);

        // Simultaneous read+reset, and reset request during a read.
        pulse_src(12'h0C0);
        ifc.RD_REQ  = 1'b1;
        ifc.RST_REQ = 1'b1;
        cyc();
        ifc.RD_REQ  = 1'b0;
        ifc.RST_REQ = 1'b0;
        check("prio_valid", 32'(ifc.SDO_VALID), 32'h1);
        for (int b = 0; b < WB; b++) begin
            check("rd_busy", 32'(ifc.BUSY), 32'h1);
            ifc.RST_REQ = (b == 5);
            ifc.BIT_STB = 1'b1;
            cyc();
        end
        ifc.BIT_STB = 1'b0;
        ifc.RST_REQ = 1'b0;
        check("prio_busy_end", 32'(ifc.BUSY), 32'h0);
        ifc.SDI = 1'b1;
        for (int b = 0; b < WB; b++) begin
            ifc.BIT_STB = 1'b1;
            cyc();
        end
        ifc.BIT_STB = 1'b0;
        ifc.SDI     = 1'b0;
        cyc();
        check("dropped_busy", 32'(ifc.BUSY), 32'h0);
        check("dropped_pend", 32'(ifc.INT_PEND), 32'h0C0);

        // Reset in the middle of shifting a reset mask aborts it.
        ifc.RST_REQ = 1'b1;
        cyc();
        ifc.RST_REQ = 1'b0;
        ifc.SDI = 1'b1;
        for (int b = 0; b < 10; b++) begin
            ifc.BIT_STB = 1'b1;
            cyc();
        end
        ifc.BIT_STB = 1'b0;
        check("mid_busy", 32'(ifc.BUSY), 32'h1);
        SIM_RST = 1'b1;
        #2;
        check("abort_busy", 32'(ifc.BUSY), 32'h0);
        check("abort_pend", 32'(ifc.INT_PEND), 32'h0);
        cyc();
        SIM_RST = 1'b0;
        for (int b = 0; b < WB; b++) begin
            ifc.BIT_STB = 1'b1;
            cyc();
        end
        ifc.BIT_STB = 1'b0;
        ifc.SDI     = 1'b0;
        cyc();
        check("abort_idle", 32'(ifc.BUSY), 32'h0);
        check("abort_pend2", 32'(ifc.INT_PEND), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) ifc.INTR_SRC = ifc.INTR_SRC ^ NI'($urandom & $urandom);
            ifc.RD_REQ  = ($urandom_range(0, 29) == 0);
            ifc.RST_REQ = ($urandom_range(0, 29) == 0);
            ifc.INH_REQ = ($urandom_range(0, 39) == 0);
            ifc.BIT_STB = ($urandom_range(0, 2) != 0);
            ifc.SDI     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) begin
                SIM_RST = 1'b1;
                cyc();
                SIM_RST = 1'b0;
            end
            cyc();
        end
        ifc.INTR_SRC = '0;
        ifc.RD_REQ   = 1'b0;
        ifc.RST_REQ  = 1'b0;
        ifc.INH_REQ  = 1'b0;
        ifc.BIT_STB  = 1'b0;
        ifc.SDI      = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
